mem_wb_bridge: RTL and testbench
================================

MEM_WB_BRIDGE -- requirements
Module: mem_wb_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0300_0000, address-window base.
REQ-002 SHALL have parameter WIN_MASK, default 32'hFF00_0000; hit = (mem_addr & WIN_MASK) == BASE_ADDR.
REQ-003 SHALL have parameter TIMEOUT, default 256, max cycles awaiting ack/err; 0 disables timeout.
REQ-004 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, read data returned on error/timeout.
REQ-005 SHALL have ports:
  clock_main  in  1   clock
  rst_n       in  1   reset, synchronous, active-low; clock clock_main
  mem_valid   in  1   CPU request valid
  mem_addr    in  32  CPU byte address
  mem_wdata   in  32  CPU write data
  mem_wstrb   in  4   byte strobes; 0 = read
  mem_ready   out 1   one-cycle completion pulse, asserted only for hit requests
  mem_rdata   out 32  read data, valid while mem_ready=1
  wbm_adr_o   out 32  Wishbone address
  wbm_dat_o   out 32  Wishbone write data
  wbm_dat_i   in  32  Wishbone read data
  wbm_we_o    out 1   write enable
  wbm_sel_o   out 4   byte select
  wbm_stb_o   out 1   strobe
  wbm_cyc_o   out 1   cycle
  wbm_ack_i   in  1   slave acknowledge
  wbm_err_i   in  1   slave error
  err_clr     in  1   clears sticky error status
  bus_err_irq out 1   level IRQ, high while sticky error set
  err_addr    out 32  address of most recent failed access
  err_cause   out 2   01 = slave err, 10 = timeout, 00 = none

Function
REQ-006 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE.
REQ-007 IDLE: on mem_valid && hit, SHALL register wbm_adr_o=mem_addr, wbm_dat_o=mem_wdata, wbm_we_o=|mem_wstrb, wbm_sel_o=mem_wstrb if write else 4'b1111, set stb/cyc=1, clear timeout counter, go WAIT.
REQ-008 Non-hit requests SHALL be ignored entirely: no Wishbone activity, mem_ready stays 0.
REQ-009 WAIT: stb/cyc/adr/dat/we/sel SHALL be held stable; counter increments each cycle.
REQ-010 WAIT, wbm_ack_i=1, wbm_err_i=0: SHALL capture mem_rdata=wbm_dat_i, drop stb/cyc/we, go RESP.
REQ-011 WAIT, wbm_err_i=1 (regardless of ack): SHALL set mem_rdata=ERR_RDATA, err_cause=01, err_addr=wbm_adr_o, drop stb/cyc/we, go RESP.
REQ-012 WAIT, TIMEOUT!=0, counter reaches TIMEOUT-1 with no ack/err: SHALL set mem_rdata=ERR_RDATA, err_cause=10, err_addr=wbm_adr_o, drop stb/cyc/we, go RESP; ack/err on that same cycle takes priority over timeout.
REQ-013 RESP: mem_ready=1 for exactly one cycle (registered), then IDLE; no new request accepted in RESP.
REQ-014 Minimum latency, request to mem_ready: 3 cycles with ack in the first WAIT cycle.
REQ-015 Error writes SHALL complete on the CPU side (mem_ready pulse); write data discarded.
REQ-016 bus_err_irq SHALL equal sticky flag; set on any error/timeout, cleared by err_clr; simultaneous set and err_clr SHALL leave flag set with new cause/addr.
REQ-017 err_clr SHALL reset err_cause to 00; err_addr retains last value.
REQ-018 mem_valid deasserting during WAIT SHALL NOT abort the Wishbone cycle; it completes normally.
REQ-019 Counter width SHALL be $clog2(TIMEOUT+1), saturating, never wrapping.

Reset
REQ-020 On rst_n=0 at clock edge: state=IDLE, all wbm_* outputs 0, mem_ready=0, mem_rdata=0, counter=0, bus_err_irq=0, err_cause=00, err_addr=0.
REQ-021 Reset mid-WAIT SHALL drop cyc/stb at the next edge; no mem_ready pulse for the aborted access.

Structure
REQ-022 FSM state encodings and err_cause codes SHALL live in shared package soc_bus_pkg.
REQ-023 Timeout counter SHALL be a sub-module bus_timeout_cnt (clear, enable, expire output); rest flat.

Verification
REQ-024 Read 0x0300_0010, ack after 2 WAIT cycles, dat_i=0x1234_5678 -> mem_ready at cycle 5, mem_rdata=0x1234_5678, sel=4'hF, we=0.
REQ-025 Write 0x0300_0004, wstrb=4'b0011, wdata=0xAABB_CCDD -> wbm_sel_o=0011, wbm_we_o=1, wbm_dat_o=0xAABB_CCDD until ack, one mem_ready pulse.
REQ-026 TIMEOUT=8, no slave response -> cyc drops after 8 WAIT cycles, mem_rdata=0xDEAD_BEEF, err_cause=10, bus_err_irq=1, err_addr=request address.
REQ-027 ack and err in same cycle -> err_cause=01, mem_rdata=ERR_RDATA; then err_clr and new err in same cycle -> irq stays 1.
REQ-028 Access 0x0000_2000 (outside window) -> wbm_cyc_o stays 0, mem_ready stays 0 for 20 cycles.
REQ-029 rst_n=0 during WAIT -> next edge all wbm_* 0, state IDLE, no mem_ready pulse.

Source files
------------

// File: rtl/soc_bus_pkg.sv
// Shared bus definitions: bridge FSM state encodings, error cause codes, and the byte-select helper.
// Latency: none (type and function declarations only).
// Backpressure: none.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'b00,
    BUS_WAIT = 2'b01,
    BUS_RESP = 2'b10
  } bus_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_SLAVE   = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } err_cause_e;

  // Reads select every byte lane; writes use the CPU strobes unchanged.
  function automatic logic [3:0] wb_sel(input logic [3:0] wstrb);
    return (|wstrb) ? wstrb : 4'b1111;
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Saturating cycle counter that flags the last allowed wait cycle of a bus access.
// Latency: expire_o is combinational from the registered count; clr_i and en_i act at the next edge.
// Backpressure: none; the counter holds at its maximum value and never wraps.
module bus_timeout_cnt #(
  parameter int TIMEOUT = 256
) (
  input  logic clock_main,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, otherwise count up while enabled and below saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clock_main) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A TIMEOUT of zero means the access is never timed out.
  assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_wb_bridge.sv
// Bridges a CPU valid/ready memory port onto a Wishbone master for one address window, with sticky error reporting.
// Latency: 3 cycles from request to mem_ready when the slave acks in the first wait cycle; each extra wait cycle adds one.
// Backpressure: waits on ack/err or timeout; requests are not accepted while an access or its response is pending.
module mem_wb_bridge
  import soc_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter logic [31:0] WIN_MASK  = 32'hFF00_0000,
  parameter int          TIMEOUT   = 256,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clock_main,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_stb_o,
  output logic        wbm_cyc_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        err_clr,
  output logic        bus_err_irq,
  output logic [31:0] err_addr,
  output logic [1:0]  err_cause
);

  bus_state_e  state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic        cyc_q, cyc_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_flag_q, err_flag_d;
  err_cause_e  cause_q, cause_d;
  logic [31:0] eaddr_q, eaddr_d;

  logic hit;
  logic cnt_clr, cnt_en, cnt_expire;

  assign hit = (mem_addr & WIN_MASK) == BASE_ADDR;

  bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock_main (clock_main),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .en_i       (cnt_en),
    .expire_o   (cnt_expire)
  );

  // Next-state and datapath decode; a new error in the same cycle overrides err_clr.
  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    we_d       = we_q;
    sel_d      = sel_q;
    cyc_d      = cyc_q;
    ready_d    = 1'b0;
    rdata_d    = rdata_q;
    err_flag_d = err_flag_q;
    cause_d    = cause_q;
    eaddr_d    = eaddr_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;

    if (err_clr) begin
      err_flag_d = 1'b0;
      cause_d    = CAUSE_NONE;
    end

    case (state_q)
      BUS_IDLE: begin
        if (mem_valid && hit) begin
          adr_d   = mem_addr;
          dat_d   = mem_wdata;
          we_d    = |mem_wstrb;
          sel_d   = wb_sel(mem_wstrb);
          cyc_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = BUS_WAIT;
        end
      end
      BUS_WAIT: begin
        cnt_en = 1'b1;
        if (wbm_err_i) begin
          rdata_d    = ERR_RDATA;
          err_flag_d = 1'b1;
          cause_d    = CAUSE_SLAVE;
          eaddr_d    = adr_q;
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          ready_d    = 1'b1;
          state_d    = BUS_RESP;
        end else if (wbm_ack_i) begin
          rdata_d = wbm_dat_i;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          ready_d = 1'b1;
          state_d = BUS_RESP;
        end else if (cnt_expire) begin
          rdata_d    = ERR_RDATA;
          err_flag_d = 1'b1;
          cause_d    = CAUSE_TIMEOUT;
          eaddr_d    = adr_q;
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          ready_d    = 1'b1;
          state_d    = BUS_RESP;
        end
      end
      BUS_RESP: begin
        state_d = BUS_IDLE;
      end
      default: begin
        state_d = BUS_IDLE;
        cyc_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears everything including the sticky error record.
  always_ff @(posedge clock_main) begin
    if (!rst_n) begin
      state_q    <= BUS_IDLE;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      cyc_q      <= 1'b0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      err_flag_q <= 1'b0;
      cause_q    <= CAUSE_NONE;
      eaddr_q    <= '0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      cyc_q      <= cyc_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      err_flag_q <= err_flag_d;
      cause_q    <= cause_d;
      eaddr_q    <= eaddr_d;
    end
  end

  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign mem_ready   = ready_q;
  assign mem_rdata   = rdata_q;
  assign bus_err_irq = err_flag_q;
  assign err_cause   = cause_q;
  assign err_addr    = eaddr_q;

endmodule

// File: tb/tb_mem_wb_bridge.sv
module tb_mem_wb_bridge;

  localparam int TP = 8;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic        err_clr;
  logic        bus_err_irq;
  logic [31:0] err_addr;
  logic [1:0]  err_cause;

  int errors = 0;
  int checks = 0;

  mem_wb_bridge #(
    .BASE_ADDR (32'h0300_0000),
    .WIN_MASK  (32'hFF00_0000),
    .TIMEOUT   (TP),
    .ERR_RDATA (DEAD)
  ) dut (
    .clock_main  (clk),
    .rst_n       (rst_n),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_err_i   (wbm_err_i),
    .err_clr     (err_clr),
    .bus_err_irq (bus_err_irq),
    .err_addr    (err_addr),
    .err_cause   (err_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          ridx;
    logic        ack;
    logic        err;
    logic [31:0] rdat;
    logic        drop;
    logic        exp_rdy;
    int          exp_lat;
    int          exp_waits;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_sel;
    logic        exp_we;
    logic        exp_irq;
    logic [1:0]  exp_cause;
    logic [31:0] exp_eaddr;
  } vec_t;

  // Drives one CPU request and a scripted slave; latency counts edges from the capture edge to the edge that samples mem_ready.
  task automatic run_txn(
    input  logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
    input  int ridx, input logic rack, input logic rerr, input logic [31:0] rdat,
    input  logic drop_vld, input logic clr_at_resp, input int budget,
    output logic got_rdy, output int lat, output int waits, output logic [31:0] rd,
    output logic [31:0] adr_s, output logic [31:0] dat_s, output logic [3:0] sel_s,
    output logic we_s, output logic stable, output logic pulse_one);
    int widx;
    got_rdy = 1'b0; lat = 0; waits = 0; rd = '0; adr_s = '0; dat_s = '0;
    sel_s = '0; we_s = 1'b0; stable = 1'b1; pulse_one = 1'b1; widx = 0;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;
    for (int k = 1; k <= budget && !got_rdy; k++) begin
      @(negedge clk);
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; err_clr = 1'b0;
      if (mem_ready) begin
        got_rdy = 1'b1; lat = k + 1; rd = mem_rdata; mem_valid = 1'b0;
      end else if (wbm_cyc_o) begin
        waits++;
        if (wbm_stb_o !== 1'b1) stable = 1'b0;
        if (widx == 0) begin
          adr_s = wbm_adr_o; dat_s = wbm_dat_o; sel_s = wbm_sel_o; we_s = wbm_we_o;
        end else if (wbm_adr_o !== adr_s || wbm_dat_o !== dat_s ||
                     wbm_sel_o !== sel_s || wbm_we_o !== we_s) begin
          stable = 1'b0;
        end
        if (drop_vld) mem_valid = 1'b0;
        if (widx == ridx) begin
          wbm_ack_i = rack; wbm_err_i = rerr; wbm_dat_i = rdat; err_clr = clr_at_resp;
        end
        widx++;
      end
    end
    mem_valid = 1'b0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0; err_clr = 1'b0;
    if (got_rdy) begin
      @(negedge clk);
      if (mem_ready || wbm_cyc_o) pulse_one = 1'b0;
    end
  endtask

  vec_t tbl[8];

  logic        g_rdy, g_we, g_stable, g_pulse;
  int          g_lat, g_waits;
  logic [31:0] g_rd, g_adr, g_dat;
  logic [3:0]  g_sel;

  // Reference error-status model.
  logic        m_irq;
  logic [1:0]  m_cause;
  logic [31:0] m_eaddr;

  initial begin
    rst_n = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    wbm_dat_i = '0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0; err_clr = 1'b0;

    //            addr          wdata         ws     ridx ack  err  rdat          drop rdy lat wt rdata         sel    we   irq  cause  eaddr
    tbl[0] = '{32'h0300_0010, 32'h0,        4'h0,  2,  1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 5, 3, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 2'b00, 32'h0};
    tbl[1] = '{32'h0300_0004, 32'hAABB_CCDD, 4'h3, 1,  1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 4, 2, 32'h0,         4'h3, 1'b1, 1'b0, 2'b00, 32'h0};
    tbl[2] = '{32'h0300_0100, 32'h0,        4'h0, -1,  1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 10, 8, DEAD,         4'hF, 1'b0, 1'b1, 2'b10, 32'h0300_0100};
    tbl[3] = '{32'h03AB_0040, 32'h0,        4'h0,  0,  1'b1, 1'b1, 32'h5555_5555, 1'b0, 1'b1, 3, 1, DEAD,          4'hF, 1'b0, 1'b1, 2'b01, 32'h03AB_0040};
    tbl[4] = '{32'h0000_2000, 32'h0,        4'h0,  0,  1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 0, 0, 32'h0,         4'h0, 1'b0, 1'b1, 2'b01, 32'h03AB_0040};
    tbl[5] = '{32'h03FF_FFFC, 32'h7700_0000, 4'h8, 3,  1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 6, 4, 32'h0,         4'h8, 1'b1, 1'b1, 2'b01, 32'h03AB_0040};
    tbl[6] = '{32'h0300_0008, 32'h0BAD_F00D, 4'hF, 0,  1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 3, 1, DEAD,          4'hF, 1'b1, 1'b1, 2'b01, 32'h0300_0008};
    tbl[7] = '{32'h0300_0020, 32'h0,        4'h0,  7,  1'b1, 1'b0, 32'h0F0F_0F0F, 1'b0, 1'b1, 10, 8, 32'h0F0F_0F0F, 4'hF, 1'b0, 1'b1, 2'b01, 32'h0300_0008};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_cyc", 32'(wbm_cyc_o), 32'h0);
    chk("rst_stb", 32'(wbm_stb_o), 32'h0);
    chk("rst_we", 32'(wbm_we_o), 32'h0);
    chk("rst_sel", 32'(wbm_sel_o), 32'h0);
    chk("rst_adr", wbm_adr_o, 32'h0);
    chk("rst_dat", wbm_dat_o, 32'h0);
    chk("rst_ready", 32'(mem_ready), 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_irq", 32'(bus_err_irq), 32'h0);
    chk("rst_cause", 32'(err_cause), 32'h0);
    chk("rst_eaddr", err_addr, 32'h0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].ridx, tbl[i].ack, tbl[i].err,
              tbl[i].rdat, tbl[i].drop, 1'b0, 20, g_rdy, g_lat, g_waits, g_rd,
              g_adr, g_dat, g_sel, g_we, g_stable, g_pulse);
      chk($sformatf("v%0d_ready", i), 32'(g_rdy), 32'(tbl[i].exp_rdy));
      chk($sformatf("v%0d_waits", i), 32'(g_waits), 32'(tbl[i].exp_waits));
      if (tbl[i].exp_rdy) begin
        chk($sformatf("v%0d_lat", i), 32'(g_lat), 32'(tbl[i].exp_lat));
        chk($sformatf("v%0d_rdata", i), g_rd, tbl[i].exp_rdata);
        chk($sformatf("v%0d_pulse", i), 32'(g_pulse), 32'h1);
        chk($sformatf("v%0d_adr", i), g_adr, tbl[i].addr);
        chk($sformatf("v%0d_dat", i), g_dat, tbl[i].wdata);
        chk($sformatf("v%0d_sel", i), 32'(g_sel), 32'(tbl[i].exp_sel));
        chk($sformatf("v%0d_we", i), 32'(g_we), 32'(tbl[i].exp_we));
        chk($sformatf("v%0d_stable", i), 32'(g_stable), 32'h1);
      end
      chk($sformatf("v%0d_irq", i), 32'(bus_err_irq), 32'(tbl[i].exp_irq));
      chk($sformatf("v%0d_cause", i), 32'(err_cause), 32'(tbl[i].exp_cause));
      chk($sformatf("v%0d_eaddr", i), err_addr, tbl[i].exp_eaddr);
    end

    // err_clr coinciding with a new slave error keeps the flag set with the new record
    run_txn(32'h0300_0200, 32'h0, 4'h0, 1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 20,
            g_rdy, g_lat, g_waits, g_rd, g_adr, g_dat, g_sel, g_we, g_stable, g_pulse);
    chk("clrset_lat", 32'(g_lat), 32'd4);
    chk("clrset_irq", 32'(bus_err_irq), 32'h1);
    chk("clrset_cause", 32'(err_cause), 32'h1);
    chk("clrset_eaddr", err_addr, 32'h0300_0200);

    // Plain err_clr: flag and cause drop, address retained
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("clr_irq", 32'(bus_err_irq), 32'h0);
    chk("clr_cause", 32'(err_cause), 32'h0);
    chk("clr_eaddr", err_addr, 32'h0300_0200);

    // Randomized transactions against the reference model
    m_irq = 1'b0; m_cause = 2'b00; m_eaddr = 32'h0300_0200;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a, wd, rdat;
      logic [3:0]  ws;
      logic        rack, rerr, drop, hit, respond, is_err;
      int          r, kind, e_lat, e_waits;
      logic [31:0] e_rd;
      if ($urandom_range(0, 9) < 7) a = {8'h03, 24'($urandom)};
      else begin
        a = $urandom;
        if (a[31:24] == 8'h03) a[31:24] = 8'h44;
      end
      wd = $urandom; rdat = $urandom;
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      r = $urandom_range(0, 11);
      kind = $urandom_range(0, 3);
      rerr = (kind <= 1);
      rack = (kind >= 1);
      drop = 1'($urandom);
      run_txn(a, wd, ws, r, rack, rerr, rdat, drop, 1'b0, 20,
              g_rdy, g_lat, g_waits, g_rd, g_adr, g_dat, g_sel, g_we, g_stable, g_pulse);
      hit = (a[31:24] == 8'h03);
      respond = (r < TP);
      is_err = respond ? rerr : 1'b1;
      e_lat = respond ? r + 3 : TP + 2;
      e_waits = hit ? (respond ? r + 1 : TP) : 0;
      e_rd = is_err ? DEAD : rdat;
      chk($sformatf("r%0d_ready", n), 32'(g_rdy), 32'(hit));
      chk($sformatf("r%0d_waits", n), 32'(g_waits), 32'(e_waits));
      if (hit) begin
        chk($sformatf("r%0d_lat", n), 32'(g_lat), 32'(e_lat));
        chk($sformatf("r%0d_rdata", n), g_rd, e_rd);
        chk($sformatf("r%0d_adr", n), g_adr, a);
        chk($sformatf("r%0d_sel", n), 32'(g_sel), (ws == 4'h0) ? 32'hF : 32'(ws));
        chk($sformatf("r%0d_we", n), 32'(g_we), 32'(ws != 4'h0));
        chk($sformatf("r%0d_stable", n), 32'(g_stable & g_pulse), 32'h1);
        if (is_err) begin
          m_irq = 1'b1; m_cause = respond ? 2'b01 : 2'b10; m_eaddr = a;
        end
      end
      chk($sformatf("r%0d_irq", n), 32'(bus_err_irq), 32'(m_irq));
      chk($sformatf("r%0d_cause", n), 32'(err_cause), 32'(m_cause));
      chk($sformatf("r%0d_eaddr", n), err_addr, m_eaddr);
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        m_irq = 1'b0; m_cause = 2'b00;
        chk($sformatf("r%0d_clr_irq", n), 32'(bus_err_irq), 32'(m_irq));
      end
    end

    // Reset in the middle of a wait: bus released at the next edge, no completion pulse
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h0300_0300; mem_wdata = 32'h1111_2222; mem_wstrb = 4'hF;
    @(negedge clk);
    chk("rstw_cyc_before", 32'(wbm_cyc_o), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstw_cyc", 32'(wbm_cyc_o), 32'h0);
    chk("rstw_stb", 32'(wbm_stb_o), 32'h0);
    chk("rstw_we", 32'(wbm_we_o), 32'h0);
    chk("rstw_sel", 32'(wbm_sel_o), 32'h0);
    chk("rstw_adr", wbm_adr_o, 32'h0);
    chk("rstw_ready", 32'(mem_ready), 32'h0);
    chk("rstw_eaddr", err_addr, 32'h0);
    rst_n = 1'b1; mem_valid = 1'b0;
    g_rdy = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_ready || wbm_cyc_o) g_rdy = 1'b1;
    end
    chk("rstw_no_pulse", 32'(g_rdy), 32'h0);

    // Bridge works normally after the aborted access
    run_txn(32'h0300_0400, 32'h0, 4'h0, 0, 1'b1, 1'b0, 32'hCAFE_0001, 1'b0, 1'b0, 20,
            g_rdy, g_lat, g_waits, g_rd, g_adr, g_dat, g_sel, g_we, g_stable, g_pulse);
    chk("post_lat", 32'(g_lat), 32'd3);
    chk("post_rdata", g_rd, 32'hCAFE_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
